// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side adapter for a one-cycle-latency synchronous FIFO.
// Issues fifo_rd_en, captures fifo_dout one cycle later into a 3-entry
// prefetch buffer, and presents the data as a valid/ready stream with
// packet boundary tagging (m_last every PKT_LEN beats) and a packet counter.
module fifo_rd_stream #(
   parameter int DATA_WIDTH = 8,
   parameter int PKT_LEN    = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last,
   output logic [CNT_WIDTH-1:0]  pkt_cnt
);

   localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

   logic [DATA_WIDTH-1:0] buf_mem [3];
   logic [1:0]            wr_ptr;
   logic [1:0]            rd_ptr;
   logic [1:0]            occ;
   logic                  inflight;
   logic [BW-1:0]         beat_cnt;
   logic                  hs;

   // Read request: only registered state and fifo_empty, never m_ready, so
   // a word already requested always has a free slot when it arrives.
   always_comb begin
      fifo_rd_en = !fifo_empty && (({1'b0, occ} + {2'b00, inflight}) < 3'd3);
   end

   // Stream outputs derived from buffer occupancy and packet position.
   always_comb begin
      m_valid = (occ != 2'd0);
      hs      = m_valid && m_ready;
      m_data  = m_valid ? buf_mem[rd_ptr] : '0;
      m_last  = m_valid && (beat_cnt == LAST_BEAT);
   end

   // Prefetch buffer: capture the word requested last cycle, release on handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < 3; i++) begin
            buf_mem[i] <= '0;
         end
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         occ      <= '0;
         inflight <= 1'b0;
      end else begin
         inflight <= fifo_rd_en;
         if (inflight) begin
            buf_mem[wr_ptr] <= fifo_dout;
            wr_ptr          <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
         end
         if (hs) begin
            rd_ptr <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
         end
         case ({inflight, hs})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

   // Packet position and completed-packet counter, advanced per handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt <= '0;
         pkt_cnt  <= '0;
      end else if (hs) begin
         if (m_last) begin
            beat_cnt <= '0;
            pkt_cnt  <= pkt_cnt + 1'b1;
         end else begin
            beat_cnt <= beat_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Testbench for fifo_rd_stream: behavioural one-cycle-latency FIFO models feed
// two instances (PKT_LEN=16 and PKT_LEN=1); expected beats are queued as words
// are written and a negedge monitor pops and compares on every handshake.
module tb_fifo_rd_stream;

   localparam int DW  = 8;
   localparam int PL  = 16;
   localparam int PL1 = 1;
   localparam int CW  = 16;
   localparam int FIFO_DEPTH = 16;

   typedef struct packed {
      logic [DW-1:0] d;
      logic          l;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          m_ready = 1'b0;

   logic [DW-1:0] fifo_dout = '0;
   logic          fifo_empty = 1'b1;
   logic          fifo_rd_en;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_last;
   logic [CW-1:0] pkt_cnt;

   logic [DW-1:0] fifo_dout1 = '0;
   logic          fifo_empty1 = 1'b1;
   logic          fifo_rd_en1;
   logic [DW-1:0] m_data1;
   logic          m_valid1;
   logic          m_last1;
   logic [CW-1:0] pkt_cnt1;

   logic [DW-1:0] fq[$];
   logic [DW-1:0] wq[$];
   logic [DW-1:0] fq1[$];
   logic [DW-1:0] wq1[$];
   exp_t          exp_q[$];
   exp_t          exp_q1[$];

   int checks = 0;
   int errors = 0;
   int wcount = 0;
   int wcount1 = 0;
   int outstanding = 0;
   logic wr_done;

   always #5 clk = ~clk;

   fifo_rd_stream #(.DATA_WIDTH(DW), .PKT_LEN(PL), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en), .m_data(m_data), .m_valid(m_valid),
      .m_ready(m_ready), .m_last(m_last), .pkt_cnt(pkt_cnt)
   );

   fifo_rd_stream #(.DATA_WIDTH(DW), .PKT_LEN(PL1), .CNT_WIDTH(CW)) dut1 (
      .clk(clk), .rst(rst), .fifo_dout(fifo_dout1), .fifo_empty(fifo_empty1),
      .fifo_rd_en(fifo_rd_en1), .m_data(m_data1), .m_valid(m_valid1),
      .m_ready(m_ready), .m_last(m_last1), .pkt_cnt(pkt_cnt1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic push0(input logic [DW-1:0] d);
      wq.push_back(d);
      exp_q.push_back(exp_t'{d: d, l: ((wcount % PL) == PL - 1)});
      wcount++;
   endtask

   task automatic push1(input logic [DW-1:0] d);
      wq1.push_back(d);
      exp_q1.push_back(exp_t'{d: d, l: ((wcount1 % PL1) == PL1 - 1)});
      wcount1++;
   endtask

   task automatic clear_expect();
      exp_q.delete();
      exp_q1.delete();
      wcount  = 0;
      wcount1 = 0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      m_ready = 1'b0;
      clear_expect();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || exp_q1.size() != 0 || m_valid || m_valid1) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({name, "_pending"}, exp_q.size() + exp_q1.size(), 0);
   endtask

   task automatic wait_valid(input string name, input int budget);
      int n = 0;
      @(negedge clk);
      while (!m_valid && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({name, "_valid_seen"}, m_valid, 1);
   endtask

   // FIFO model for the PKT_LEN=16 instance: one-cycle read latency, depth 16.
   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         fq.delete();
         wq.delete();
         fifo_empty <= 1'b1;
         fifo_dout  <= '0;
      end else begin
         if (fifo_rd_en && fq.size() != 0) fifo_dout <= fq.pop_front();
         if (wq.size() != 0 && fq.size() < FIFO_DEPTH) fq.push_back(wq.pop_front());
         fifo_empty <= (fq.size() == 0);
      end
   end

   // FIFO model for the PKT_LEN=1 instance.
   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         fq1.delete();
         wq1.delete();
         fifo_empty1 <= 1'b1;
         fifo_dout1  <= '0;
      end else begin
         if (fifo_rd_en1 && fq1.size() != 0) fifo_dout1 <= fq1.pop_front();
         if (wq1.size() != 0 && fq1.size() < FIFO_DEPTH) fq1.push_back(wq1.pop_front());
         fifo_empty1 <= (fq1.size() == 0);
      end
   end

   // Monitor: compare every handshake against the expectation queues.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (rst) begin
         outstanding = 0;
      end else begin
         check("rd_en_while_empty", fifo_rd_en && fifo_empty, 0);
         check("occ_plus_inflight_le3", outstanding <= 3, 1);
         check("last_without_valid", m_last && !m_valid, 0);
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", m_data);
            end else begin
               e = exp_q.pop_front();
               check("beat_data", m_data, e.d);
               check("beat_last", m_last, e.l);
            end
         end
         outstanding = outstanding + int'(fifo_rd_en) - int'(m_valid && m_ready);

         check("rd_en1_while_empty", fifo_rd_en1 && fifo_empty1, 0);
         if (m_valid1 && m_ready) begin
            if (exp_q1.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat1: got data 0x%0h, expected no beat", m_data1);
            end else begin
               e = exp_q1.pop_front();
               check("beat1_data", m_data1, e.d);
               check("beat1_last", m_last1, e.l);
            end
         end
      end
   end

   initial begin
      int n;
      int pulses;

      // Reset state
      #2;
      check("rst_m_valid", m_valid, 0);
      check("rst_rd_en", fifo_rd_en, 0);
      check("rst_pkt_cnt", pkt_cnt, 0);
      check("rst_m_data", m_data, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // 1: 20 words streamed back to back, one packet completed
      m_ready = 1'b1;
      for (int i = 1; i <= 20; i++) push0(8'(i));
      wait_valid("t1", 20);
      for (int i = 0; i < 20; i++) begin
         check("t1_no_gap", m_valid, 1);
         @(negedge clk);
      end
      check("t1_idle_after", m_valid, 0);
      check("t1_pkt_cnt", pkt_cnt, 1);

      // 2: backpressure limits prefetch to 3 reads
      do_reset();
      for (int i = 1; i <= 8; i++) push0(8'(i));
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (fifo_rd_en) pulses++;
      end
      check("t2_rd_pulses", pulses, 3);
      check("t2_hold_valid", m_valid, 1);
      check("t2_hold_data", m_data, 8'd1);
      @(negedge clk);
      check("t2_hold_data_stable", m_data, 8'd1);
      @(posedge clk);
      #1 m_ready = 1'b1;
      wait_drain("t2", 100);
      check("t2_pkt_cnt", pkt_cnt, 0);

      // 3: random ready and write timing over 200 words
      do_reset();
      wr_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 200; i++) begin
               push0(8'($urandom_range(0, 255)));
               repeat ($urandom_range(0, 2)) @(posedge clk);
            end
            wr_done = 1'b1;
         end
         begin
            int k = 0;
            while (!(wr_done && exp_q.size() == 0) && k < 4000) begin
               @(posedge clk);
               #1 m_ready = 1'($urandom_range(0, 1));
               k++;
            end
         end
      join
      m_ready = 1'b1;
      wait_drain("t3", 200);
      check("t3_pkt_cnt", pkt_cnt, 12);

      // 4: single word latency
      do_reset();
      m_ready = 1'b1;
      push0(8'hA5);
      n = 0;
      @(negedge clk);
      while (fifo_empty && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t4_empty_fell", fifo_empty, 0);
      check("t4_rd_en_T", fifo_rd_en, 1);
      check("t4_valid_T", m_valid, 0);
      @(negedge clk);
      check("t4_rd_en_T1", fifo_rd_en, 0);
      check("t4_valid_T1", m_valid, 0);
      @(negedge clk);
      check("t4_valid_T2", m_valid, 1);
      check("t4_data_T2", m_data, 8'hA5);
      @(negedge clk);
      check("t4_valid_T3", m_valid, 0);

      // 5: asynchronous reset with a full buffer mid-packet
      do_reset();
      for (int i = 1; i <= 12; i++) push0(8'(i));
      repeat (10) @(negedge clk);
      @(posedge clk);
      #1 m_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1 m_ready = 1'b0;
      repeat (10) @(negedge clk);
      check("t5_prefull_valid", m_valid, 1);
      check("t5_prefull_data", m_data, 8'd6);
      #2 rst = 1'b1;
      #1;
      check("t5_async_valid", m_valid, 0);
      check("t5_async_last", m_last, 0);
      check("t5_async_rd_en", fifo_rd_en, 0);
      check("t5_async_pkt_cnt", pkt_cnt, 0);
      check("t5_async_data", m_data, 0);
      clear_expect();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      m_ready = 1'b1;
      for (int i = 1; i <= 16; i++) push0(8'(i));
      wait_drain("t5", 100);
      check("t5_pkt_cnt", pkt_cnt, 1);

      // 6: PKT_LEN=1, every beat is last
      do_reset();
      m_ready = 1'b1;
      for (int i = 1; i <= 5; i++) push1(8'(8'h30 + i));
      wait_drain("t6", 100);
      check("t6_pkt_cnt", pkt_cnt1, 5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
Read-side adapter placed directly downstream of syncfifo configured with FWFT_EN=0, i.e. one-cycle read latency. It drives the FIFO's rd_en, captures dout one cycle later into a 3-entry prefetch buffer, and presents the data as a valid/ready stream at full throughput. fifo_rd_en has no combinational path from m_ready. It also tags packet boundaries (m_last every PKT_LEN beats) and counts completed packets.

Parameters:
DATA_WIDTH, 8, data width; must equal the syncfifo DATA_WIDTH.
PKT_LEN, 16, beats per packet, >=1; sets m_last spacing.
CNT_WIDTH, 16, width of pkt_cnt.

Ports:
clk  input  1  clock; all logic is rising-edge.
rst  input  1  asynchronous, active-high reset.
fifo_dout  input  DATA_WIDTH  syncfifo dout, valid in the cycle after fifo_rd_en was high.
fifo_empty  input  1  syncfifo empty flag.
fifo_rd_en  output  1  syncfifo rd_en.
m_data  output  DATA_WIDTH  stream data.
m_valid  output  1  stream valid.
m_ready  input  1  stream ready from the consumer.
m_last  output  1  last beat of a packet.
pkt_cnt  output  CNT_WIDTH  count of completed packets (handshakes with m_last=1); wraps.

Behaviour:
- Interface fixed: one clock, clk; rst is asynchronous, active-high.
- Reset values: fifo_rd_en=0, m_valid=0, m_last=0, m_data=0, pkt_cnt=0. Internal state also clears: occ=0, inflight=0, beat_cnt=0, buffer pointers=0.
- Internal state:
  - 3-entry circular buffer with wr_ptr/rd_ptr (mod 3).
  - occ, range 0..3.
  - inflight, a register equal to the fifo_rd_en value of the previous cycle.
  - beat_cnt, range 0..PKT_LEN-1.
- fifo_rd_en = !fifo_empty && (occ + inflight < 3). The expression is combinational from fifo_empty and registered state only.
- Capture: when inflight=1, fifo_dout is written at buffer[wr_ptr] on the clock edge; wr_ptr advances and occ increments.
- Pop: a handshake is m_valid && m_ready. On a handshake, rd_ptr advances and occ decrements. A capture and a pop in the same cycle leave occ unchanged.
- m_valid = (occ != 0). m_data = buffer[rd_ptr] when m_valid=1, and 0 otherwise. Once m_valid is asserted, m_data is held stable until the handshake.
- Latency:
  - fifo_empty falls in cycle T, so fifo_rd_en is high in T.
  - FIFO dout is valid in T+1 and captured at the end of T+1.
  - m_valid=1 from T+2.
  - Steady state with m_ready=1: one beat per cycle, no bubbles.
- Backpressure: with m_ready=0, at most 3 reads are issued; fifo_rd_en then stays low. No word is dropped or duplicated, and occ never exceeds 3.
- m_last = m_valid && (beat_cnt == PKT_LEN-1).
- On a handshake, beat_cnt increments, or returns to 0 if m_last=1. pkt_cnt increments when m_last=1 and wraps modulo 2^CNT_WIDTH.
- PKT_LEN=1: m_last=m_valid; beat_cnt is held at 0.
- Buffer pointer wrap: 2 -> 0.
- fifo_empty must never be violated: rd_en is not issued when fifo_empty=1.
- Reset mid-operation: all outputs go to their reset values immediately (asynchronous). Buffered and in-flight words are discarded, and the packet position restarts at beat 0. The upstream FIFO is expected to share the reset.

Test Plan:
1. Reset release, then write 1..20 into syncfifo (DATA_WIDTH=8, ADDR_WIDTH=4), m_ready=1 constant -> m_data 1..16 then 17..20 on consecutive cycles with no gaps after the first beat; m_last only on data 16; pkt_cnt=1 at the end; 4 beats of packet 2 pending.
2. FIFO holding 1..8, m_ready=0 -> exactly 3 fifo_rd_en pulses, then low; m_valid=1 with m_data=1 stable. Raise m_ready -> 1..8 in order, no loss or duplicates.
3. Random m_ready at 50% over 200 words (random FIFO writes) -> output sequence equals write sequence; fifo_rd_en never high while fifo_empty=1; occ+inflight<=3 at all times.
4. Empty FIFO, single write of 0xA5 -> fifo_rd_en for 1 cycle; m_valid rises 2 cycles after fifo_empty falls; one beat 0xA5; m_valid then returns to 0.
5. Assert rst asynchronously mid-cycle with occ=3 and beat_cnt=5 -> m_valid, m_last, fifo_rd_en and pkt_cnt are 0 immediately. After release and a new write of 1..16, m_last falls on data 16.
6. PKT_LEN=1, 5 words with m_ready=1 -> m_last=1 on all 5 beats; pkt_cnt=5.
